executor_microprograma: RTL and testbench

- Consumer and sequencer side of the microprogram control memory (`memoria`).
- Drives the 4-bit step counter `contagem` into `memoria`. Receives the combinational control word `saida` and immediate `valor` back from it.
- Executes each control word on the X/Y/Z register datapath with its adder ULA, one step per clock.
- On `start`, runs steps 0..LAST_STEP, then presents Z and pulses `done`.

---
 rtl/microprograma_pkg.sv | 17 +
 rtl/executor_microprograma_ula.sv | 16 +
 rtl/executor_microprograma.sv | 135 +++++++++++++
 tb/tb_executor_microprograma.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microprograma_pkg.sv
// Shared opcodes and FSM state encoding for the microprogram executor.
package microprograma_pkg;

    localparam logic [3:0] OP_LOAD_X  = 4'b0000;
    localparam logic [3:0] OP_LOAD_Y  = 4'b0001;
    localparam logic [3:0] OP_SOMA    = 4'b0010;
    localparam logic [3:0] OP_SHR_Y   = 4'b0011;
    localparam logic [3:0] OP_STORE_Z = 4'b0100;

    // StIdle waits for start, StRun executes one step per clock, StDone pulses done.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/executor_microprograma_ula.sv
// ULA: combinational WIDTH-bit adder with carry out.
module ula #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    // Full-width add, carry is the extra top bit.
    always_comb begin
        {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
    end

endmodule

// File: rtl/executor_microprograma.sv
// Microprogram sequencer: steps contagem through memoria and executes each control
// word on the X/Y/Z datapath, one step per clock.
module executor_microprograma
    import microprograma_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LAST_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       saida,
    input  logic [WIDTH-1:0] valor,
    output logic [3:0]       contagem,
    output logic [WIDTH-1:0] z_out,
    output logic             carry,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [3:0] LastStep = 4'(LAST_STEP);

    state_e           state_q, state_d;
    logic [3:0]       contagem_q, contagem_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] soma;
    logic             soma_carry;

    ula #(
        .WIDTH(WIDTH)
    ) u_ula (
        .a_i    (x_q),
        .b_i    (y_q),
        .sum_o  (soma),
        .carry_o(soma_carry)
    );

    // Next-state: FSM sequencing, step counter and control-word decode.
    always_comb begin
        state_d    = state_q;
        contagem_d = contagem_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        carry_d    = carry_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                contagem_d = 4'd0;
                if (start) begin
                    // X/Y/Z are left alone; the microprogram clears them itself.
                    state_d = StRun;
                    err_d   = 1'b0;
                    carry_d = 1'b0;
                end
            end
            StRun: begin
                case (saida)
                    OP_LOAD_X: begin
                        x_d = valor;
                        y_d = '0;
                        z_d = '0;
                    end
                    OP_LOAD_Y: y_d = valor;
                    OP_SOMA: begin
                        y_d     = soma;
                        carry_d = soma_carry;
                    end
                    OP_SHR_Y: y_d = y_q >> 1;
                    OP_STORE_Z: begin
                        z_d = y_q;
                        x_d = '0;
                        y_d = '0;
                    end
                    default: err_d = 1'b1;
                endcase
                if (contagem_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    contagem_d = contagem_q + 4'd1;
                end
            end
            StDone: begin
                contagem_d = 4'd0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            contagem_q <= 4'd0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            carry_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            contagem_q <= contagem_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            carry_q    <= carry_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign contagem = contagem_q;
    assign z_out    = z_q;
    assign carry    = carry_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_executor_microprograma.sv
// Bench for executor_microprograma: behavioural memoria plus an arithmetic reference model.
module tb_executor_microprograma;

    localparam int W = 4;
    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         start0 = 1'b0;
    logic [3:0]   saida, saida0;
    logic [W-1:0] valor, valor0;
    logic [3:0]   contagem, contagem0;
    logic [W-1:0] z_out, z_out0;
    logic         carry, busy, done, err;
    logic         carry0, busy0, done0, err0;

    // Behavioural memoria shared by both instances.
    logic [3:0]   mem_op  [16];
    logic [W-1:0] mem_val [16];

    assign saida  = mem_op[contagem];
    assign valor  = mem_val[contagem];
    assign saida0 = mem_op[contagem0];
    assign valor0 = mem_val[contagem0];

    executor_microprograma #(.WIDTH(W), .LAST_STEP(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .saida(saida), .valor(valor),
        .contagem(contagem), .z_out(z_out), .carry(carry), .busy(busy), .done(done),
        .err(err)
    );

    executor_microprograma #(.WIDTH(W), .LAST_STEP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .saida(saida0), .valor(valor0),
        .contagem(contagem0), .z_out(z_out0), .carry(carry0), .busy(busy0), .done(done0),
        .err(err0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: plain integers.
    int mx, my, mz, mc, me;

    task automatic model_step(input int op, input int val);
        int s;
        case (op)
            0: begin mx = val; my = 0; mz = 0; end
            1: my = val;
            2: begin s = mx + my; my = s % (1 << W); mc = s / (1 << W); end
            3: my = my / 2;
            4: begin mz = my; mx = 0; my = 0; end
            default: me = 1;
        endcase
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mz = 0; mc = 0; me = 0;
    endtask

    task automatic load_memoria();
        for (int i = 0; i < 16; i++) begin mem_op[i] = 4'hf; mem_val[i] = '0; end
        mem_op[0] = 4'd0; mem_val[0] = 4'd2;
        mem_op[1] = 4'd1; mem_val[1] = 4'd4;
        mem_op[2] = 4'd2;
        mem_op[3] = 4'd3;
        mem_op[4] = 4'd4;
    endtask

    // One full run on the main instance with per-step checks against the model.
    task automatic run_check(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mc = 0; me = 0;
        total++;
        if (busy !== 1'b1 || err !== 1'b0 || carry !== 1'b0) begin
            bad++;
            $display("FAIL %s start: busy=%0b err=%0b carry=%0b want 1 0 0", tag, busy, err, carry);
        end
        for (int k = 0; k <= L; k++) begin
            total++;
            if (contagem !== 4'(k) || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s step%0d seq: contagem=%0d busy=%0b done=%0b want %0d 1 0",
                         tag, k, contagem, busy, done, k);
            end
            model_step(int'(mem_op[k]), int'(mem_val[k]));
            @(posedge clk);
            #1;
            total++;
            if (z_out !== 4'(mz) || carry !== 1'(mc) || err !== 1'(me)) begin
                bad++;
                $display("FAIL %s step%0d regs: z=%0d carry=%0b err=%0b want %0d %0d %0d",
                         tag, k, z_out, carry, err, mz, mc, me);
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || contagem !== 4'(L)) begin
            bad++;
            $display("FAIL %s done: done=%0b busy=%0b contagem=%0d want 1 0 %0d",
                     tag, done, busy, contagem, L);
        end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || contagem !== 4'd0) begin
            bad++;
            $display("FAIL %s idle: done=%0b busy=%0b contagem=%0d want 0 0 0",
                     tag, done, busy, contagem);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (contagem !== 4'd0 || z_out !== 4'd0 || carry !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset: contagem=%0d z=%0d carry=%0b busy=%0b done=%0b err=%0b want 0",
                     contagem, z_out, carry, busy, done, err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_memoria();
        load_memoria();
        run_check("memoria");
        total++;
        if (z_out !== 4'd3 || carry !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL memoria final: z=%0d carry=%0b err=%0b want 3 0 0", z_out, carry, err);
        end
    endtask

    task automatic test_carry();
        load_memoria();
        mem_val[0] = 4'd9; mem_val[1] = 4'd9;
        mem_op[3] = 4'd4;
        mem_op[4] = 4'd1; mem_val[4] = 4'd0;
        run_check("carry");
        total++;
        if (z_out !== 4'd2 || carry !== 1'b1) begin
            bad++;
            $display("FAIL carry final: z=%0d carry=%0b want 2 1", z_out, carry);
        end
    endtask

    task automatic test_err();
        load_memoria();
        mem_op[2] = 4'b1111;
        run_check("err");
        total++;
        if (err !== 1'b1 || z_out !== 4'd2) begin
            bad++;
            $display("FAIL err sticky: err=%0b z=%0d want 1 2", err, z_out);
        end
        load_memoria();
        run_check("err_clear");
    endtask

    task automatic test_start_held();
        int per;
        int ph;
        int dones;
        logic exp_busy, exp_done;
        logic [3:0] exp_cnt;
        per = L + 3;
        dones = 0;
        load_memoria();
        @(negedge clk);
        start = 1'b1;
        for (int n = 1; n <= 2 * per; n++) begin
            @(posedge clk);
            #1;
            ph = (n - 1) % per;
            exp_busy = (ph <= L);
            exp_done = (ph == L + 1);
            exp_cnt = (ph <= L) ? 4'(ph) : ((ph == L + 1) ? 4'(L) : 4'd0);
            if (done === 1'b1) dones++;
            total++;
            if (busy !== exp_busy || done !== exp_done || contagem !== exp_cnt) begin
                bad++;
                $display("FAIL held n=%0d: busy=%0b done=%0b contagem=%0d want %0b %0b %0d",
                         n, busy, done, contagem, exp_busy, exp_done, exp_cnt);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (dones != 2 || busy !== 1'b0) begin
            bad++;
            $display("FAIL held count: dones=%0d busy=%0b want 2 0", dones, busy);
        end
        for (int r = 0; r < 2; r++) begin
            mc = 0; me = 0;
            for (int k = 0; k <= L; k++) model_step(int'(mem_op[k]), int'(mem_val[k]));
        end
    endtask

    task automatic test_reset_midrun();
        load_memoria();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (contagem !== 4'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun pre: contagem=%0d busy=%0b want 3 1", contagem, busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (contagem !== 4'd0 || z_out !== 4'd0 || carry !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL midrun reset: contagem=%0d z=%0d carry=%0b busy=%0b done=%0b err=%0b",
                     contagem, z_out, carry, busy, done, err);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || contagem !== 4'd0) begin
                bad++;
                $display("FAIL midrun idle%0d: busy=%0b done=%0b contagem=%0d want 0 0 0",
                         i, busy, done, contagem);
            end
        end
        run_check("after_reset");
        total++;
        if (z_out !== 4'd3) begin
            bad++;
            $display("FAIL after_reset z: got %0d want 3", z_out);
        end
    endtask

    task automatic test_last_step0();
        load_memoria();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        total++;
        if (busy0 !== 1'b1 || contagem0 !== 4'd0) begin
            bad++;
            $display("FAIL last0 run: busy=%0b contagem=%0d want 1 0", busy0, contagem0);
        end
        @(posedge clk);
        #1;
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || contagem0 !== 4'd0 || z_out0 !== 4'd0 ||
            err0 !== 1'b0) begin
            bad++;
            $display("FAIL last0 done: done=%0b busy=%0b contagem=%0d z=%0d err=%0b want 1 0 0 0 0",
                     done0, busy0, contagem0, z_out0, err0);
        end
        @(posedge clk);
        #1;
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b0 || contagem0 !== 4'd0) begin
            bad++;
            $display("FAIL last0 idle: done=%0b busy=%0b contagem=%0d want 0 0 0",
                     done0, busy0, contagem0);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) begin
                sel = $urandom_range(0, 5);
                mem_op[i]  = (sel == 5) ? 4'($urandom_range(5, 15)) : 4'(sel);
                mem_val[i] = 4'($urandom_range(0, 15));
            end
            run_check("random");
        end
    endtask

    initial begin
        test_reset();
        test_memoria();
        test_carry();
        test_err();
        test_start_held();
        test_reset_midrun();
        test_last_step0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
